// File: rtl/window_3x3_if.sv
// Pixel stream in / 3x3 window out bundle between the pixel source,
// window_3x3 and the layer_1 consumer.
interface window_3x3_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PW    = 9
);
  logic                       pxl_valid;
  logic [PW-1:0]              pxl_in;
  logic                       win_valid;
  logic [9*PW-1:0]            win_out;
  logic [$clog2(IMG_H)-1:0]   win_row;
  logic [$clog2(IMG_W)-1:0]   win_col;
  logic                       frame_done;

  modport master (
    output pxl_valid, pxl_in,
    input  win_valid, win_out, win_row, win_col, frame_done
  );

  modport slave (
    input  pxl_valid, pxl_in,
    output win_valid, win_out, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window_3x3.sv
// Sliding 3x3 window generator: buffers two image rows plus the incoming pixel
// and presents every complete neighbourhood in parallel, one clock after acceptance.
module window_3x3 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PW    = 9
) (
  input  logic         clk,
  input  logic         reset,
  window_3x3_if.slave  bus
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  // The pixel being accepted is the newest tap, so only 2*IMG_W+2 older words are stored.
  localparam int DEPTH = 2*IMG_W + 2;

  logic [PW-1:0]   line_p0 [DEPTH];
  logic [CW-1:0]   col_p0;
  logic [RW-1:0]   row_p0;
  logic            last_col_p0;
  logic            last_row_p0;
  logic            hit_p0;
  logic            done_p0;
  logic [9*PW-1:0] win_p0;

  logic            vld_p1;
  logic            done_p1;
  logic [9*PW-1:0] win_p1;
  logic [RW-1:0]   row_p1;
  logic [CW-1:0]   col_p1;

  assign last_col_p0 = (col_p0 == CW'(IMG_W-1));
  assign last_row_p0 = (row_p0 == RW'(IMG_H-1));
  assign hit_p0      = bus.pxl_valid && (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
  assign done_p0     = bus.pxl_valid && last_col_p0 && last_row_p0;

  // ---- stage p0: raster position of the pixel being accepted ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (bus.pxl_valid) begin
      if (last_col_p0) begin
        col_p0 <= '0;
        row_p0 <= last_row_p0 ? '0 : row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  // Line buffer is data only; stale words are never exposed because hit_p0 needs row >= 2.
  always_ff @(posedge clk) begin
    if (bus.pxl_valid) begin
      line_p0[0] <= bus.pxl_in;
      for (int k = 1; k < DEPTH; k++) line_p0[k] <= line_p0[k-1];
    end
  end

  // Slice (r,c) is the pixel (2-r) rows and (2-c) columns behind the incoming one.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      localparam int AGE = (2-r)*IMG_W + (2-c);
      if (AGE == 0) begin : g_new
        assign win_p0[PW*(3*r+c) +: PW] = bus.pxl_in;
      end else begin : g_old
        assign win_p0[PW*(3*r+c) +: PW] = line_p0[AGE-1];
      end
    end
  end

  // ---- stage p1: registered window, centre position and strobes ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      win_p1  <= '0;
      row_p1  <= '0;
      col_p1  <= '0;
    end else begin
      vld_p1  <= hit_p0;
      done_p1 <= done_p0;
      if (hit_p0) begin
        win_p1 <= win_p0;
        row_p1 <= row_p0 - RW'(1);
        col_p1 <= col_p0 - CW'(1);
      end
    end
  end

  assign bus.win_valid  = vld_p1;
  assign bus.frame_done = done_p1;
  assign bus.win_out    = win_p1;
  assign bus.win_row    = row_p1;
  assign bus.win_col    = col_p1;

endmodule

// File: tb/tb_window_3x3.sv
// Bench for window_3x3: a 4x4 instance driven from a vector table and hand sequences,
// and a 28x28 instance driven with patterned and random frames against an image model.
module tb_window_3x3;
  localparam int PW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_3x3_if #(.IMG_W(4),  .IMG_H(4),  .PW(PW)) a_if ();
  window_3x3_if #(.IMG_W(28), .IMG_H(28), .PW(PW)) b_if ();

  window_3x3 #(.IMG_W(4),  .IMG_H(4),  .PW(PW)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  window_3x3 #(.IMG_W(28), .IMG_H(28), .PW(PW)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  typedef struct {
    int pix;
    bit vld;
    bit done;
    int row;
    int col;
    int win [9];
  } vec_t;

  vec_t tbl [16];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: whole-image arrays indexed by (row, col) derived from a pixel count.
  int W [2] = '{4, 28};
  int H [2] = '{4, 28};
  int npix [2];
  int img [2][28][28];
  int ewin [2][9];
  int erow [2];
  int ecol [2];
  bit ev [2];
  bit ed [2];
  int pulses [2];
  int rmin, rmax, cmin, cmax;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic model_reset(input int d);
    npix[d] = 0;
    ev[d] = 1'b0;
    ed[d] = 1'b0;
    erow[d] = 0;
    ecol[d] = 0;
    for (int k = 0; k < 9; k++) ewin[d][k] = 0;
  endtask

  task automatic step(input int d, input bit v, input int p);
    int r, c;
    bit gv, gd;
    int gr, gc;
    int gw [9];
    @(negedge clk);
    if (d == 0) begin a_if.pxl_valid = v; a_if.pxl_in = PW'(p); end
    else        begin b_if.pxl_valid = v; b_if.pxl_in = PW'(p); end
    @(posedge clk);
    #1;
    if (d == 0) begin
      a_if.pxl_valid = 1'b0;
      gv = a_if.win_valid; gd = a_if.frame_done;
      gr = int'(a_if.win_row); gc = int'(a_if.win_col);
      for (int k = 0; k < 9; k++) gw[k] = int'(a_if.win_out[PW*k +: PW]);
    end else begin
      b_if.pxl_valid = 1'b0;
      gv = b_if.win_valid; gd = b_if.frame_done;
      gr = int'(b_if.win_row); gc = int'(b_if.win_col);
      for (int k = 0; k < 9; k++) gw[k] = int'(b_if.win_out[PW*k +: PW]);
    end
    ev[d] = 1'b0;
    ed[d] = 1'b0;
    if (v) begin
      r = npix[d] / W[d];
      c = npix[d] % W[d];
      img[d][r][c] = p % (1 << PW);
      if (r >= 2 && c >= 2) begin
        ev[d] = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ewin[d][3*i+j] = img[d][r-2+i][c-2+j];
        erow[d] = r - 1;
        ecol[d] = c - 1;
      end
      ed[d] = (npix[d] == W[d]*H[d] - 1);
      npix[d] = (npix[d] + 1) % (W[d]*H[d]);
    end
    if (gv) begin
      pulses[d]++;
      if (d == 1) begin
        if (gr < rmin) rmin = gr;
        if (gr > rmax) rmax = gr;
        if (gc < cmin) cmin = gc;
        if (gc > cmax) cmax = gc;
      end
    end
    check($sformatf("dut%0d win_valid", d), int'(gv), int'(ev[d]));
    check($sformatf("dut%0d frame_done", d), int'(gd), int'(ed[d]));
    check($sformatf("dut%0d win_row", d), gr, erow[d]);
    check($sformatf("dut%0d win_col", d), gc, ecol[d]);
    for (int k = 0; k < 9; k++)
      check($sformatf("dut%0d win_out[%0d]", d, k), gw[k], ewin[d][k]);
  endtask

  task automatic run_table();
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, tbl[i].pix);
      check($sformatf("tbl[%0d] win_valid", i), int'(a_if.win_valid), int'(tbl[i].vld));
      check($sformatf("tbl[%0d] frame_done", i), int'(a_if.frame_done), int'(tbl[i].done));
      if (tbl[i].vld) begin
        check($sformatf("tbl[%0d] win_row", i), int'(a_if.win_row), tbl[i].row);
        check($sformatf("tbl[%0d] win_col", i), int'(a_if.win_col), tbl[i].col);
        for (int k = 0; k < 9; k++)
          check($sformatf("tbl[%0d] slice%0d", i, k), int'(a_if.win_out[PW*k +: PW]), tbl[i].win[k]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a win_valid"},  int'(a_if.win_valid), 0);
    check({tag, " a frame_done"}, int'(a_if.frame_done), 0);
    check({tag, " a win_row"},    int'(a_if.win_row), 0);
    check({tag, " a win_col"},    int'(a_if.win_col), 0);
    check({tag, " a win_out"},    int'(a_if.win_out != '0), 0);
    check({tag, " b win_valid"},  int'(b_if.win_valid), 0);
    check({tag, " b win_out"},    int'(b_if.win_out != '0), 0);
  endtask

  initial begin
    int f2 [9];
    f2 = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = i; tbl[i].vld = 1'b0; tbl[i].done = 1'b0;
      tbl[i].row = 0; tbl[i].col = 0;
      for (int k = 0; k < 9; k++) tbl[i].win[k] = 0;
    end
    tbl[10].vld = 1'b1; tbl[10].row = 1; tbl[10].col = 1;
    tbl[10].win = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    tbl[11].vld = 1'b1; tbl[11].row = 1; tbl[11].col = 2;
    tbl[11].win = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    tbl[14].vld = 1'b1; tbl[14].row = 2; tbl[14].col = 1;
    tbl[14].win = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    tbl[15].vld = 1'b1; tbl[15].row = 2; tbl[15].col = 2; tbl[15].done = 1'b1;
    tbl[15].win = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    reset = 1'b1;
    a_if.pxl_valid = 1'b0; a_if.pxl_in = '0;
    b_if.pxl_valid = 1'b0; b_if.pxl_in = '0;
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    check_zero("in reset");
    reset = 1'b0;

    // Idle after reset: outputs stay at zero whatever is on pxl_in.
    for (int i = 0; i < 50; i++) step(0, 1'b0, int'($urandom_range(0, 511)));
    for (int i = 0; i < 50; i++) step(1, 1'b0, int'($urandom_range(0, 511)));

    // 4x4 frame, back to back, against the vector table.
    pulses[0] = 0;
    run_table();
    check("frame1 pulse count", pulses[0], 4);

    // Same frame with gaps between pixels.
    pulses[0] = 0;
    for (int p = 0; p < 16; p++) begin
      int gap;
      gap = (p % 2 == 0) ? 2 : int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) step(0, 1'b0, int'($urandom_range(0, 511)));
      step(0, 1'b1, p);
    end
    step(0, 1'b0, 0);
    check("gapped pulse count", pulses[0], 4);

    // Two frames back to back; the second must not mix in first-frame data.
    pulses[0] = 0;
    for (int p = 0; p < 16; p++) step(0, 1'b1, p);
    for (int p = 100; p < 116; p++) begin
      step(0, 1'b1, p);
      if (p == 110) begin
        check("f2 first valid", int'(a_if.win_valid), 1);
        for (int k = 0; k < 9; k++)
          check($sformatf("f2 first slice%0d", k), int'(a_if.win_out[PW*k +: PW]), f2[k]);
      end
    end
    check("two-frame pulse count", pulses[0], 8);

    // Reset between edges mid-frame while a window is being presented.
    for (int p = 0; p <= 10; p++) step(0, 1'b1, p);
    check("pre-reset valid", int'(a_if.win_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset(0); model_reset(1);
    pulses[0] = 0;
    run_table();
    check("post-reset pulse count", pulses[0], 4);

    // 28x28, 255 / 9'h1FF alternating.
    pulses[1] = 0;
    rmin = 1000; rmax = -1; cmin = 1000; cmax = -1;
    for (int n = 0; n < 784; n++) step(1, 1'b1, (n % 2 == 1) ? 511 : 255);
    check("28x28 pulse count", pulses[1], 676);
    check("win_row min", rmin, 1);
    check("win_row max", rmax, 26);
    check("win_col min", cmin, 1);
    check("win_col max", cmax, 26);

    // 28x28 random pixels with occasional gaps.
    pulses[1] = 0;
    for (int n = 0; n < 784; n++) begin
      if ($urandom_range(0, 7) == 0) step(1, 1'b0, int'($urandom_range(0, 511)));
      step(1, 1'b1, int'($urandom_range(0, 511)));
    end
    step(1, 1'b0, 0);
    check("random frame pulse count", pulses[1], 676);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
